// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared types for the rggen APB bridge
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_APB_BRIDGE_IDLE,
    RGGEN_APB_BRIDGE_SETUP,
    RGGEN_APB_BRIDGE_ACCESS,
    RGGEN_APB_BRIDGE_RESPONSE
  } rggen_apb_bridge_state_e;

  localparam logic [2:0] RGGEN_APB_PPROT = 3'b000;

endpackage

// File: rtl/rggen_apb_if.sv
// rtl/rggen_apb_if.sv - APB4 signal bundle with requester and completer views
interface rggen_apb_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);

  logic                     psel;
  logic                     penable;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [2:0]               pprot;
  logic                     pwrite;
  logic [BUS_WIDTH/8-1:0]   pstrb;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic                     pready;
  logic [BUS_WIDTH-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/rggen_apb_bridge_timer.sv
// rtl/rggen_apb_bridge_timer.sv - ACCESS-phase wait-state counter for the APB bridge
module rggen_apb_bridge_timer #(
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    logic unused_inputs;
    assign unused_inputs = ^{i_clk, i_rst_n, clear, enable};
    assign expired       = 1'b0;
  end else begin : g_enabled
    localparam int                COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST   = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] count;

    // expired fires during the wait cycle that brings the count up to the limit
    assign expired = enable && (count == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        count <= '0;
      end else if (clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rggen_apb_bridge_master.sv
// rtl/rggen_apb_bridge_master.sv - command/response to APB4 requester bridge
module rggen_apb_bridge_master
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic                     o_rsp_error,
  output logic                     o_rsp_timeout,
  rggen_apb_if.master              apb_if
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int ADDRESS_LSB  = $clog2(STROBE_WIDTH);
  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    ~ADDRESS_WIDTH'((1 << ADDRESS_LSB) - 1);

  rggen_apb_bridge_state_e  state;
  logic                     cmd_ready;
  logic                     rsp_valid;
  logic [BUS_WIDTH-1:0]     rsp_read_data;
  logic                     rsp_error;
  logic                     rsp_timeout;
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [BUS_WIDTH-1:0]     pwdata;
  logic [STROBE_WIDTH-1:0]  pstrb;
  logic                     timer_clear;
  logic                     timer_enable;
  logic                     timer_expired;
  logic                     access_done;

  assign timer_clear  = (state == RGGEN_APB_BRIDGE_SETUP);
  assign timer_enable = (state == RGGEN_APB_BRIDGE_ACCESS) && !apb_if.pready;
  assign access_done  = apb_if.pready || timer_expired;

  rggen_apb_bridge_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= RGGEN_APB_BRIDGE_IDLE;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_read_data <= '0;
      rsp_error     <= 1'b0;
      rsp_timeout   <= 1'b0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      pwrite        <= 1'b0;
      paddr         <= '0;
      pwdata        <= '0;
      pstrb         <= '0;
    end else begin
      case (state)
        RGGEN_APB_BRIDGE_IDLE: begin
          // APB address/data registers double as the latched command
          if (i_cmd_valid) begin
            state     <= RGGEN_APB_BRIDGE_SETUP;
            cmd_ready <= 1'b0;
            psel      <= 1'b1;
            paddr     <= i_cmd_address & ADDRESS_MASK;
            pwrite    <= i_cmd_write;
            pwdata    <= i_cmd_write ? i_cmd_write_data : '0;
            pstrb     <= i_cmd_write ? i_cmd_strobe : '0;
          end
        end
        RGGEN_APB_BRIDGE_SETUP: begin
          state   <= RGGEN_APB_BRIDGE_ACCESS;
          penable <= 1'b1;
        end
        RGGEN_APB_BRIDGE_ACCESS: begin
          if (access_done) begin
            state     <= RGGEN_APB_BRIDGE_RESPONSE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
          end
          // a completer answer wins over a coincident timeout
          if (apb_if.pready) begin
            rsp_read_data <= pwrite ? '0 : apb_if.prdata;
            rsp_error     <= apb_if.pslverr;
            rsp_timeout   <= 1'b0;
          end else if (timer_expired) begin
            rsp_read_data <= '0;
            rsp_error     <= 1'b1;
            rsp_timeout   <= 1'b1;
          end
        end
        RGGEN_APB_BRIDGE_RESPONSE: begin
          if (i_rsp_ready) begin
            state     <= RGGEN_APB_BRIDGE_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: begin
          state <= RGGEN_APB_BRIDGE_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready     = cmd_ready;
  assign o_rsp_valid     = rsp_valid;
  assign o_rsp_read_data = rsp_read_data;
  assign o_rsp_error     = rsp_error;
  assign o_rsp_timeout   = rsp_timeout;

  assign apb_if.psel    = psel;
  assign apb_if.penable = penable;
  assign apb_if.paddr   = paddr;
  assign apb_if.pprot   = RGGEN_APB_PPROT;
  assign apb_if.pwrite  = pwrite;
  assign apb_if.pstrb   = pstrb;
  assign apb_if.pwdata  = pwdata;

endmodule
